// File: rtl/jump_pkg.sv
`default_nettype none
// ============================================================================
// jump_pkg : shared op encoding, error-address helper and firmware labels
// Rev 1.0
// ============================================================================
package jump_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        CALL    = 3'd2,
        RET     = 3'd3,
        ILLEGAL = 3'd4
    } op_e;

    // Table slots used by the firmware min/max loop
    localparam int LOOP_I     = 0;
    localparam int LOOP_J     = 1;
    localparam int UPDATE_MAX = 2;
    localparam int UPDATE_MIN = 3;
    localparam int END_J      = 4;

    function automatic logic [63:0] default_err_addr(input int unsigned width);
        if (width >= 64)
            return '1;
        else
            return (64'd1 << width) - 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jump_target_table_if.sv
`default_nettype none
// ============================================================================
// jump_target_table_if : request/write/result bundle for jump_target_table
// Rev 1.0
// ============================================================================
interface jump_target_table_if #(
    parameter int PTR_W  = 3,
    parameter int ADDR_W = 8
);
    logic              Lookup;
    logic [PTR_W-1:0]  Jptr;
    logic              Call;
    logic [ADDR_W-1:0] RetPC;
    logic              Ret;
    logic              Wr_en;
    logic [PTR_W-1:0]  Wr_ptr;
    logic [ADDR_W-1:0] Wr_addr;
    logic [ADDR_W-1:0] Jump;
    logic              JumpValid;
    logic              JumpErr;
    logic              RasEmpty;
    logic              RasFull;

    modport master (
        output Lookup, Jptr, Call, RetPC, Ret, Wr_en, Wr_ptr, Wr_addr,
        input  Jump, JumpValid, JumpErr, RasEmpty, RasFull
    );

    modport slave (
        input  Lookup, Jptr, Call, RetPC, Ret, Wr_en, Wr_ptr, Wr_addr,
        output Jump, JumpValid, JumpErr, RasEmpty, RasFull
    );
endinterface
`default_nettype wire

// File: rtl/ret_addr_stack.sv
`default_nettype none
// ============================================================================
// ret_addr_stack : non-wrapping LIFO of return addresses with occupancy count
// Rev 1.0
// ============================================================================
module ret_addr_stack #(
    parameter int ADDR_W    = 8,
    parameter int RAS_DEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              push_i,
    input  wire logic              pop_i,
    input  wire logic [ADDR_W-1:0] push_data_i,
    output logic      [ADDR_W-1:0] top_o,
    output logic                   empty_o,
    output logic                   full_o
);
    localparam int IDX_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic              w_do_push, w_do_pop;
    logic [IDX_W-1:0]  w_wr_idx, w_top_idx;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(RAS_DEPTH));
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;
    assign w_wr_idx  = count_q[IDX_W-1:0];
    assign w_top_idx = IDX_W'(count_q - CNT_W'(1));
    assign top_o     = mem_q[w_top_idx];

    always_comb begin
        count_d = count_q;
        if (w_do_push && !w_do_pop)
            count_d = count_q + CNT_W'(1);
        else if (w_do_pop && !w_do_push)
            count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    // Entries above the count are dead, so storage needs no reset
    always_ff @(posedge clk) begin
        if (w_do_push)
            mem_q[w_wr_idx] <= push_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/jump_target_table.sv
`default_nettype none
// ============================================================================
// jump_target_table : registered jump-pointer lookup with valid bits and RAS
// Rev 1.0
// ============================================================================
module jump_target_table
    import jump_pkg::*;
#(
    parameter int              PTR_W     = 3,
    parameter int              ADDR_W    = 8,
    parameter int              RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] ERR_ADDR = ADDR_W'(default_err_addr(ADDR_W))
) (
    input wire logic           Clk,
    input wire logic           Reset,
    jump_target_table_if.slave bus
);
    localparam int DEPTH = 2 ** PTR_W;

    logic [ADDR_W-1:0] table_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;

    logic [ADDR_W-1:0] jump_q, jump_d;
    logic              jvalid_q, jvalid_d;
    logic              jerr_q, jerr_d;

    op_e               w_op;
    logic              w_wr_hit;
    logic [ADDR_W-1:0] w_ent_data;
    logic              w_ent_valid;
    logic              w_push, w_pop;
    logic [ADDR_W-1:0] w_ras_top;
    logic              w_ras_empty, w_ras_full;

    // Same-cycle write to the looked-up slot is forwarded (write-first)
    assign w_wr_hit    = bus.Wr_en && (bus.Wr_ptr == bus.Jptr);
    assign w_ent_data  = w_wr_hit ? bus.Wr_addr : table_q[bus.Jptr];
    assign w_ent_valid = w_wr_hit || valid_q[bus.Jptr];

    always_comb begin
        if (bus.Call && bus.Ret)
            w_op = ILLEGAL;
        else if (bus.Ret)
            w_op = RET;
        else if (bus.Call)
            w_op = CALL;
        else if (bus.Lookup)
            w_op = LOOKUP;
        else
            w_op = IDLE;
    end

    always_comb begin
        jump_d   = jump_q;
        jvalid_d = 1'b0;
        jerr_d   = 1'b0;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        case (w_op)
            LOOKUP: begin
                jvalid_d = 1'b1;
                jump_d   = w_ent_valid ? w_ent_data : ERR_ADDR;
                jerr_d   = !w_ent_valid;
            end
            CALL: begin
                jvalid_d = 1'b1;
                if (w_ras_full) begin
                    jump_d = ERR_ADDR;
                    jerr_d = 1'b1;
                end else begin
                    w_push = 1'b1;
                    jump_d = w_ent_valid ? w_ent_data : ERR_ADDR;
                    jerr_d = !w_ent_valid;
                end
            end
            RET: begin
                jvalid_d = 1'b1;
                if (w_ras_empty) begin
                    jump_d = ERR_ADDR;
                    jerr_d = 1'b1;
                end else begin
                    w_pop  = 1'b1;
                    jump_d = w_ras_top;
                end
            end
            ILLEGAL: begin
                jvalid_d = 1'b1;
                jump_d   = ERR_ADDR;
                jerr_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            jump_q   <= ERR_ADDR;
            jvalid_q <= 1'b0;
            jerr_q   <= 1'b0;
            valid_q  <= '0;
        end else begin
            jump_q   <= jump_d;
            jvalid_q <= jvalid_d;
            jerr_q   <= jerr_d;
            if (bus.Wr_en)
                valid_q[bus.Wr_ptr] <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (bus.Wr_en)
            table_q[bus.Wr_ptr] <= bus.Wr_addr;
    end

    ret_addr_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (Clk),
        .rst         (Reset),
        .push_i      (w_push),
        .pop_i       (w_pop),
        .push_data_i (bus.RetPC),
        .top_o       (w_ras_top),
        .empty_o     (w_ras_empty),
        .full_o      (w_ras_full)
    );

    assign bus.Jump      = jump_q;
    assign bus.JumpValid = jvalid_q;
    assign bus.JumpErr   = jerr_q;
    assign bus.RasEmpty  = w_ras_empty;
    assign bus.RasFull   = w_ras_full;

endmodule
`default_nettype wire

// File: tb/tb_jump_target_table.sv
`default_nettype none
// ============================================================================
// tb_jump_target_table : directed vector table plus RAS corner sequences
// Rev 1.0
// ============================================================================
module tb_jump_target_table;
    import jump_pkg::*;

    typedef struct {
        string      name;
        logic       rst;
        logic       lk;
        logic       call;
        logic       ret;
        logic [2:0] jptr;
        logic [7:0] retpc;
        logic       wr;
        logic [2:0] wptr;
        logic [7:0] waddr;
        logic [7:0] ej;
        logic       ev;
        logic       ee;
        logic       eem;
        logic       efu;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    jump_target_table_if #(.PTR_W(3), .ADDR_W(8)) bus ();

    jump_target_table #(
        .PTR_W     (3),
        .ADDR_W    (8),
        .RAS_DEPTH (4)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    function automatic vec_t mk(input string nm, input logic r, lk, cl, rt,
                                input logic [2:0] jp, input logic [7:0] rpc,
                                input logic w, input logic [2:0] wp,
                                input logic [7:0] wa, input logic [7:0] ej,
                                input logic ev, ee, eem, efu);
        vec_t v;
        v.name = nm; v.rst = r; v.lk = lk; v.call = cl; v.ret = rt;
        v.jptr = jp; v.retpc = rpc; v.wr = w; v.wptr = wp; v.waddr = wa;
        v.ej = ej; v.ev = ev; v.ee = ee; v.eem = eem; v.efu = efu;
        return v;
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step(input vec_t v);
        rst         = v.rst;
        bus.Lookup  = v.lk;
        bus.Call    = v.call;
        bus.Ret     = v.ret;
        bus.Jptr    = v.jptr;
        bus.RetPC   = v.retpc;
        bus.Wr_en   = v.wr;
        bus.Wr_ptr  = v.wptr;
        bus.Wr_addr = v.waddr;
        @(posedge clk);
        #1;
        check({v.name, ".Jump"},      bus.Jump,              v.ej);
        check({v.name, ".JumpValid"}, {7'd0, bus.JumpValid}, {7'd0, v.ev});
        check({v.name, ".JumpErr"},   {7'd0, bus.JumpErr},   {7'd0, v.ee});
        check({v.name, ".RasEmpty"},  {7'd0, bus.RasEmpty},  {7'd0, v.eem});
        check({v.name, ".RasFull"},   {7'd0, bus.RasFull},   {7'd0, v.efu});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        bus.Lookup = 0; bus.Call = 0; bus.Ret = 0; bus.Jptr = '0; bus.RetPC = '0;
        bus.Wr_en = 0; bus.Wr_ptr = '0; bus.Wr_addr = '0;

        //               name        rst lk cl rt jptr           retpc  wr wptr            waddr  ej     ev ee em fu
        vecs.push_back(mk("reset",    1, 0, 0, 0, 3'd0,          8'h00, 0, 3'd0,          8'h00, 8'hFF, 0, 0, 1, 0));
        vecs.push_back(mk("lk_inv2",  0, 1, 0, 0, 3'(UPDATE_MAX), 8'h00, 0, 3'd0,          8'h00, 8'hFF, 1, 1, 1, 0));
        vecs.push_back(mk("idle0",    0, 0, 0, 0, 3'd0,          8'h00, 0, 3'd0,          8'h00, 8'hFF, 0, 0, 1, 0));
        vecs.push_back(mk("wr0",      0, 0, 0, 0, 3'd0,          8'h00, 1, 3'(LOOP_I),    8'h00, 8'hFF, 0, 0, 1, 0));
        vecs.push_back(mk("wr1",      0, 0, 0, 0, 3'd0,          8'h00, 1, 3'(LOOP_J),    8'h04, 8'hFF, 0, 0, 1, 0));
        vecs.push_back(mk("wr4",      0, 0, 0, 0, 3'd0,          8'h00, 1, 3'(END_J),     8'h1D, 8'hFF, 0, 0, 1, 0));
        vecs.push_back(mk("lk4",      0, 1, 0, 0, 3'(END_J),     8'h00, 0, 3'd0,          8'h00, 8'h1D, 1, 0, 1, 0));
        vecs.push_back(mk("lk1",      0, 1, 0, 0, 3'(LOOP_J),    8'h00, 0, 3'd0,          8'h00, 8'h04, 1, 0, 1, 0));
        vecs.push_back(mk("lk0",      0, 1, 0, 0, 3'(LOOP_I),    8'h00, 0, 3'd0,          8'h00, 8'h00, 1, 0, 1, 0));
        vecs.push_back(mk("wrfirst3", 0, 1, 0, 0, 3'(UPDATE_MIN), 8'h00, 1, 3'(UPDATE_MIN), 8'h1B, 8'h1B, 1, 0, 1, 0));
        vecs.push_back(mk("idle1",    0, 0, 0, 0, 3'd0,          8'h00, 0, 3'd0,          8'h00, 8'h1B, 0, 0, 1, 0));
        vecs.push_back(mk("wr2_lk3",  0, 1, 0, 0, 3'(UPDATE_MIN), 8'h00, 1, 3'(UPDATE_MAX), 8'h20, 8'h1B, 1, 0, 1, 0));
        vecs.push_back(mk("lk_inv5",  0, 1, 0, 0, 3'd5,          8'h00, 0, 3'd0,          8'h00, 8'hFF, 1, 1, 1, 0));
        vecs.push_back(mk("lk2",      0, 1, 0, 0, 3'(UPDATE_MAX), 8'h00, 0, 3'd0,          8'h00, 8'h20, 1, 0, 1, 0));
        vecs.push_back(mk("ret_emp0", 0, 0, 0, 1, 3'd0,          8'h00, 0, 3'd0,          8'h00, 8'hFF, 1, 1, 1, 0));

        foreach (vecs[i]) step(vecs[i]);

        // Fill the RAS; slot 5 is never written so the second call errors but still pushes
        step(mk("call_10", 0, 0, 1, 0, 3'(LOOP_J), 8'h10, 0, 3'd0, 8'h00, 8'h04, 1, 0, 0, 0));
        step(mk("call_11", 0, 0, 1, 0, 3'd5,       8'h11, 0, 3'd0, 8'h00, 8'hFF, 1, 1, 0, 0));
        step(mk("call_12", 0, 0, 1, 0, 3'(END_J),  8'h12, 0, 3'd0, 8'h00, 8'h1D, 1, 0, 0, 0));
        step(mk("call_13", 0, 0, 1, 0, 3'(LOOP_I), 8'h13, 0, 3'd0, 8'h00, 8'h00, 1, 0, 0, 1));
        step(mk("call_ovf", 0, 0, 1, 0, 3'(LOOP_J), 8'h14, 0, 3'd0, 8'h00, 8'hFF, 1, 1, 0, 1));
        for (int k = 0; k < 4; k++) begin
            step(mk($sformatf("ret%0d", k), 0, 0, 0, 1, 3'd0, 8'h00, 0, 3'd0, 8'h00,
                    8'h13 - 8'(k), 1, 0, (k == 3), 0));
        end
        step(mk("ret_unf", 0, 0, 0, 1, 3'd0, 8'h00, 0, 3'd0, 8'h00, 8'hFF, 1, 1, 1, 0));

        // Call and Ret together must leave the two stacked entries intact
        step(mk("callA", 0, 0, 1, 0, 3'(LOOP_J), 8'h40, 0, 3'd0, 8'h00, 8'h04, 1, 0, 0, 0));
        step(mk("callB", 0, 0, 1, 0, 3'(LOOP_J), 8'h41, 0, 3'd0, 8'h00, 8'h04, 1, 0, 0, 0));
        step(mk("illegal", 0, 1, 1, 1, 3'(LOOP_J), 8'h77, 0, 3'd0, 8'h00, 8'hFF, 1, 1, 0, 0));
        step(mk("retB", 0, 0, 0, 1, 3'd0, 8'h00, 0, 3'd0, 8'h00, 8'h41, 1, 0, 0, 0));
        step(mk("retA", 0, 0, 0, 1, 3'd0, 8'h00, 0, 3'd0, 8'h00, 8'h40, 1, 0, 1, 0));

        // Reset mid-sequence clears stack and valid bits even with a request pending
        step(mk("callC", 0, 0, 1, 0, 3'(END_J), 8'h50, 0, 3'd0, 8'h00, 8'h1D, 1, 0, 0, 0));
        step(mk("callD", 0, 0, 1, 0, 3'(END_J), 8'h51, 0, 3'd0, 8'h00, 8'h1D, 1, 0, 0, 0));
        step(mk("rst_mid", 1, 1, 0, 0, 3'(END_J), 8'h00, 1, 3'd6, 8'h66, 8'hFF, 0, 0, 1, 0));
        step(mk("lk4_post", 0, 1, 0, 0, 3'(END_J), 8'h00, 0, 3'd0, 8'h00, 8'hFF, 1, 1, 1, 0));
        step(mk("lk6_post", 0, 1, 0, 0, 3'd6, 8'h00, 0, 3'd0, 8'h00, 8'hFF, 1, 1, 1, 0));
        step(mk("ret_post", 0, 0, 0, 1, 3'd0, 8'h00, 0, 3'd0, 8'h00, 8'hFF, 1, 1, 1, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
